// File: rtl/multi_key_debounce_pkg.sv
// Shared types and elaboration helpers for the multi-key push-button conditioner.
package multi_key_debounce_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_fsm_e;

  // One counter serves both debounce and long-press timing, so it must hold
  // the larger of the two terminal values (max - 1).
  function automatic int cnt_width(input int debounce_cycles, input int long_cycles);
    int m;
    m = (debounce_cycles > long_cycles) ? debounce_cycles : long_cycles;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

  // Channel parameter sanity: debounce >= 2, long press >= 1, sync >= 2.
  function automatic bit channel_params_legal(input int debounce_cycles,
                                              input int long_cycles,
                                              input int sync_stages);
    return (debounce_cycles >= 2) && (long_cycles >= 1) && (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/multi_key_debounce_channel.sv
// One key channel: synchroniser, polarity normalisation, debounce FSM with a
// shared debounce/long-press counter, and registered level/event outputs.
module key_debounce_channel
  import multi_key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int SYNC_STAGES       = 2,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LP_LAST = CW'(LONG_PRESS_CYCLES - 1);
  // Pin level when the key is not pressed.
  localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0);

  if (!channel_params_legal(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES, SYNC_STAGES)) begin : g_bad_params
    $error("key_debounce_channel: illegal DEBOUNCE_CYCLES/LONG_PRESS_CYCLES/SYNC_STAGES");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   active;

  key_fsm_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          long_done_q, long_done_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  // Synchroniser chain; reset loads the idle pin level so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
    end
  end

  // Normalised sample: 1 means the key is pressed regardless of pin polarity.
  assign active = sync_q[SYNC_STAGES-1] ^ IDLE_LEVEL;

  // FSM, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  // Next-state, counter and event decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (active) begin
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!active) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!active) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q != LP_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (active) begin
          // Bounce back to pressed: hold timing restarts, long_done is kept.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          release_d   = 1'b1;
          level_d     = 1'b0;
          long_done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Long press fires on the edge the hold counter lands on its terminal
    // value; this also covers LONG_PRESS_CYCLES == 1 at PRESSED entry.
    if ((state_d == PRESSED) && (cnt_d == LP_LAST) && !long_done_q) begin
      long_d      = 1'b1;
      long_done_d = 1'b1;
    end
  end

  assign key_state   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: rtl/multi_key_debounce.sv
// N-channel push-button conditioner: independent debounce channels plus a
// combined event flag.
module multi_key_debounce
  import multi_key_debounce_pkg::*;
#(
  parameter int N_KEYS            = 4,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int SYNC_STAGES       = 2,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              any_event
);

  if (N_KEYS < 1) begin : g_bad_keys
    $error("multi_key_debounce: N_KEYS must be at least 1");
  end

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
    key_debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .SYNC_STAGES      (SYNC_STAGES),
      .ACTIVE_LOW       (ACTIVE_LOW)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in[gi]),
      .key_state  (key_state[gi]),
      .key_press  (key_press[gi]),
      .key_release(key_release[gi]),
      .key_long   (key_long[gi])
    );
  end

  // Pulses are registered per channel, so this OR is clean within the cycle.
  assign any_event = |(key_press | key_release | key_long);

endmodule

// File: tb/tb_multi_key_debounce.sv
// Self-checking bench for multi_key_debounce: directed scenarios followed by
// random key activity, every cycle compared against a run-length reference model.
module tb_multi_key_debounce;

  localparam int N  = 4;
  localparam int D  = 8;
  localparam int L  = 32;
  localparam int S  = 2;
  localparam int AL = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key_in = '1;
  logic [N-1:0] key_state, key_press, key_release, key_long;
  logic         any_event;

  multi_key_debounce #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L),
    .SYNC_STAGES(S), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .any_event(any_event)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int t        = 0;

  // Reference model: delay line of normalised pin samples, then per-channel
  // run lengths and hold-segment timestamps.
  bit           pipe     [N][S];
  bit           m_level  [N];
  int           m_run    [N];
  int           m_seg_t  [N];
  bit           m_seg_ok [N];
  bit           m_ldone  [N];
  logic [N-1:0] e_state, e_press, e_rel, e_long;

  // Observed-pulse bookkeeping for the directed timing checks.
  int           c_press [N];
  int           c_rel   [N];
  int           c_long  [N];
  int           t_press [N];
  int           t_rel   [N];
  int           t_long  [N];
  int           c_any;
  logic [N-1:0] press_vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h (step %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic clear_obs();
    for (int c = 0; c < N; c++) begin
      c_press[c] = 0; c_rel[c] = 0; c_long[c] = 0;
      t_press[c] = -1; t_rel[c] = -1; t_long[c] = -1;
    end
    c_any = 0;
    press_vec = '0;
  endtask

  task automatic model_edge(input logic [N-1:0] pins, input logic r);
    bit s;
    for (int c = 0; c < N; c++) begin
      e_press[c] = 1'b0; e_rel[c] = 1'b0; e_long[c] = 1'b0;
      if (r) begin
        for (int k = 0; k < S; k++) pipe[c][k] = 1'b0;
        m_level[c] = 1'b0; m_run[c] = 0; m_seg_ok[c] = 1'b0; m_ldone[c] = 1'b0;
      end else begin
        s = pipe[c][S-1];
        for (int k = S-1; k > 0; k--) pipe[c][k] = pipe[c][k-1];
        pipe[c][0] = (AL != 0) ? !pins[c] : pins[c];
        // A new level is accepted after D+1 consecutive samples that differ from it.
        m_run[c] = (s != m_level[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == D + 1) begin
          m_run[c]   = 0;
          m_level[c] = !m_level[c];
          if (m_level[c]) begin
            e_press[c] = 1'b1; m_seg_t[c] = t; m_seg_ok[c] = 1'b1;
          end else begin
            e_rel[c] = 1'b1; m_ldone[c] = 1'b0; m_seg_ok[c] = 1'b0;
          end
        end else if (m_level[c]) begin
          if (!s) m_seg_ok[c] = 1'b0;
          else if (!m_seg_ok[c]) begin
            m_seg_ok[c] = 1'b1; m_seg_t[c] = t;
          end
        end
        // Long press: an unbroken active hold segment lasting L-1 edges past its start.
        if (m_level[c] && m_seg_ok[c] && !m_ldone[c] && (t - m_seg_t[c] == L - 1)) begin
          e_long[c] = 1'b1; m_ldone[c] = 1'b1;
        end
      end
      e_state[c] = m_level[c];
    end
  endtask

  task automatic step(input logic [N-1:0] pins, input logic r);
    @(negedge clk);
    key_in = pins;
    rst    = r;
    @(posedge clk);
    t++;
    model_edge(pins, r);
    #1;
    chk("key_state",   32'(key_state),   32'(e_state));
    chk("key_press",   32'(key_press),   32'(e_press));
    chk("key_release", 32'(key_release), 32'(e_rel));
    chk("key_long",    32'(key_long),    32'(e_long));
    chk("any_event",   32'(any_event),   32'(|(e_press | e_rel | e_long)));
    for (int c = 0; c < N; c++) begin
      if (key_press[c])   begin c_press[c]++; t_press[c] = t; end
      if (key_release[c]) begin c_rel[c]++;   t_rel[c]   = t; end
      if (key_long[c])    begin c_long[c]++;  t_long[c]  = t; end
    end
    if (any_event) begin
      c_any++;
      press_vec = key_press;
    end
  endtask

  task automatic hold(input logic [N-1:0] pins, input int n);
    for (int i = 0; i < n; i++) step(pins, 1'b0);
  endtask

  initial begin
    int t0;
    int rem [N];
    logic [N-1:0] rpins;

    clear_obs();
    // Reset
    for (int i = 0; i < 3; i++) step(4'hF, 1'b1);
    chk("reset_outputs", 32'({key_state, key_press, key_release, key_long, any_event}), 32'd0);
    hold(4'hF, 5);

    // Clean press on ch0
    clear_obs();
    t0 = t + 1;
    hold(4'b1110, 20);
    chk("clean_press_count", 32'(c_press[0]), 32'd1);
    chk("clean_press_latency", 32'(t_press[0] - t0), 32'd10);
    chk("clean_no_long", 32'(c_long[0]), 32'd0);
    chk("clean_other_quiet", 32'(c_press[1] + c_press[2] + c_press[3]), 32'd0);
    hold(4'hF, 15);
    chk("clean_release_count", 32'(c_rel[0]), 32'd1);

    // Bounce on ch1
    clear_obs();
    hold(4'b1101, 3); hold(4'hF, 3); hold(4'b1101, 3); hold(4'hF, 3);
    t0 = t + 1;
    hold(4'b1101, 15);
    chk("bounce_press_count", 32'(c_press[1]), 32'd1);
    chk("bounce_press_latency", 32'(t_press[1] - t0), 32'd10);
    t0 = t + 1;
    hold(4'hF, 15);
    chk("bounce_release_count", 32'(c_rel[1]), 32'd1);
    chk("bounce_release_latency", 32'(t_rel[1] - t0), 32'd10);

    // Long hold on ch2 with a short release glitch after key_long
    clear_obs();
    t0 = t + 1;
    hold(4'b1011, 50); hold(4'hF, 4); hold(4'b1011, 15);
    chk("long_count", 32'(c_long[2]), 32'd1);
    chk("long_latency", 32'(t_long[2] - (t0 + 10)), 32'd31);
    chk("long_glitch_no_release", 32'(c_rel[2]), 32'd0);
    hold(4'hF, 15);
    chk("long_release_count", 32'(c_rel[2]), 32'd1);

    // Simultaneous press on ch0 and ch3
    clear_obs();
    hold(4'b0110, 12);
    chk("simul_event_cycles", 32'(c_any), 32'd1);
    chk("simul_press_vec", 32'(press_vec), 32'h9);
    hold(4'hF, 15);

    // Reset during PRESS_WAIT on ch0, key kept low through reset
    clear_obs();
    hold(4'b1110, 5);
    step(4'b1110, 1'b1);
    chk("rst_abort_no_pulse", 32'(c_any), 32'd0);
    t0 = t + 1;
    hold(4'b1110, 14);
    chk("rst_repress_latency", 32'(t_press[0] - t0), 32'd10);
    hold(4'hF, 15);

    // Active run ending exactly at the debounce boundary on ch3
    clear_obs();
    hold(4'b0111, 8); hold(4'hF, 12);
    chk("boundary_reject", 32'(c_press[3]), 32'd0);

    // 7-cycle glitch on ch1
    clear_obs();
    hold(4'b1101, 7); hold(4'hF, 12);
    chk("glitch_no_event", 32'(c_any), 32'd0);
    chk("glitch_state", 32'(key_state), 32'd0);

    // Random key activity with occasional reset
    rpins = '1;
    for (int c = 0; c < N; c++) rem[c] = int'($urandom_range(1, 45));
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < N; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          rpins[c] = ~rpins[c];
          rem[c]   = int'($urandom_range(1, 45));
        end
      end
      step(rpins, ($urandom_range(0, 299) == 0));
    end
    hold(4'hF, 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
